// File: rtl/led_bcm_scheduler.sv
// BCM refresh scheduler for a HUB75 panel: walks row/bit-plane slots, requests
// column shifts, and sequences weighted on-time, blank, latch and row address.
module led_bcm_scheduler #(
  parameter int ROW_BITS   = 5,
  parameter int PLANES     = 4,
  parameter int BASE_TICKS = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic                shift_req,
  output logic [ROW_BITS-1:0] shift_row,
  output logic [2:0]          shift_plane,
  input  logic                shift_ack,
  input  logic                shift_done,
  output logic [1:0]          blank,
  output logic [1:0]          latch,
  output logic [ROW_BITS-1:0] led_addr,
  output logic                frame_start
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_BLANK, S_LATCH, S_UNBLANK, S_DRAIN
  } state_t;

  localparam logic [2:0] LAST_PLANE = 3'(PLANES - 1);

  state_t              state;
  logic [ROW_BITS-1:0] nxt_row;
  logic [2:0]          nxt_plane;
  logic [2:0]          disp_plane;
  logic [15:0]         timer;
  logic                done_flag;

  // Timer is loaded in the unblank cycle and blank rises one cycle after it
  // reaches zero, so two cycles of the weighted on-time are already spent.
  function automatic logic [15:0] on_load(input logic [2:0] plane);
    logic [15:0] ticks;
    ticks = 16'(BASE_TICKS) << plane;
    return (ticks > 16'd2) ? ticks - 16'd2 : 16'd0;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      blank       <= 2'b11;
      latch       <= 2'b00;
      led_addr    <= '0;
      shift_req   <= 1'b0;
      shift_row   <= '0;
      shift_plane <= '0;
      frame_start <= 1'b0;
      timer       <= '0;
      nxt_row     <= '0;
      nxt_plane   <= '0;
      disp_plane  <= '0;
      done_flag   <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (timer != 16'd0) timer <= timer - 16'd1;

      unique case (state)
        S_IDLE: begin
          blank     <= 2'b11;
          latch     <= 2'b00;
          nxt_row   <= '0;
          nxt_plane <= '0;
          if (enable) begin
            state       <= S_REQ;
            shift_req   <= 1'b1;
            shift_row   <= '0;
            shift_plane <= '0;
          end
        end

        S_REQ: begin
          done_flag <= 1'b0;
          if (shift_ack) begin
            state     <= S_WAIT;
            shift_req <= 1'b0;
          end
        end

        S_WAIT: begin
          if (shift_done) done_flag <= 1'b1;
          if ((done_flag || shift_done) && timer == 16'd0) begin
            state <= S_BLANK;
            blank <= 2'b11;
          end
        end

        // Row address and frame marker move on the same edge that raises latch.
        S_BLANK: begin
          state       <= S_LATCH;
          latch       <= 2'b11;
          led_addr    <= shift_row;
          disp_plane  <= shift_plane;
          frame_start <= (shift_row == '0) && (shift_plane == 3'd0);
        end

        S_LATCH: begin
          state <= S_UNBLANK;
          blank <= 2'b00;
          latch <= 2'b00;
          if (nxt_plane == LAST_PLANE) begin
            nxt_plane <= '0;
            nxt_row   <= nxt_row + ROW_BITS'(1);
          end else begin
            nxt_plane <= nxt_plane + 3'd1;
          end
        end

        S_UNBLANK: begin
          timer <= on_load(disp_plane);
          if (enable) begin
            state       <= S_REQ;
            shift_req   <= 1'b1;
            shift_row   <= nxt_row;
            shift_plane <= nxt_plane;
          end else begin
            state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (timer == 16'd0) begin
            blank <= 2'b11;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_bcm_scheduler.sv
// Self-checking bench for led_bcm_scheduler: behavioural shifter, output monitor,
// and a slot/on-time reference model driven by randomized shifter timing.
module tb_led_bcm_scheduler;
  localparam int ROW_BITS   = 5;
  localparam int PLANES     = 4;
  localparam int BASE_TICKS = 64;
  localparam int NROWS      = 1 << ROW_BITS;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b0;
  logic                shift_req, shift_ack, shift_done, frame_start;
  logic [ROW_BITS-1:0] shift_row, led_addr;
  logic [2:0]          shift_plane;
  logic [1:0]          blank, latch;

  led_bcm_scheduler #(.ROW_BITS(ROW_BITS), .PLANES(PLANES), .BASE_TICKS(BASE_TICKS)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .shift_req(shift_req), .shift_row(shift_row), .shift_plane(shift_plane),
    .shift_ack(shift_ack), .shift_done(shift_done),
    .blank(blank), .latch(latch), .led_addr(led_addr), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Shifter behaviour knobs and observations
  int ack_dly = 0, done_dly = 40;
  bit rnd_mode = 0, slow_p1 = 0, spurious = 0;
  int last_done = -1000000;
  int req_unstable = 0, hs_err = 0, req_hi = 0;

  // One record per display period (blank=00 run)
  typedef struct {
    int u; int len; int done; int lat_cyc; int lat_addr; int lat_fs; int lat_n; int gap;
  } per_t;
  per_t per_q[$];
  int   fs_q[$];
  int   illegal = 0;

  // Reference model: next displayed slot
  int m_row = 0, m_plane = 0;
  bit m_fresh = 1;

  // Behavioural column shifter
  initial begin
    int st = 0, cnt = 0, a = 0, d = 0;
    logic [ROW_BITS-1:0] r0;
    logic [2:0]          p0;
    r0 = '0; p0 = '0;
    shift_ack = 1'b0; shift_done = 1'b0;
    forever begin
      @(negedge clk);
      shift_ack = 1'b0; shift_done = 1'b0;
      if (reset) st = 0;
      else if (st != 2) begin
        if (st == 0 && shift_req === 1'b1) begin
          st = 1; cnt = 0; r0 = shift_row; p0 = shift_plane; req_hi = 0;
          a = rnd_mode ? int'($urandom_range(0, 4)) : ack_dly;
          d = rnd_mode ? int'($urandom_range(1, 160))
                       : ((slow_p1 && shift_plane == 3'd1) ? 100 : done_dly);
        end
        if (st == 1) begin
          req_hi++;
          if (shift_req !== 1'b1 || shift_row !== r0 || shift_plane !== p0) req_unstable++;
          if (cnt == a) begin
            shift_ack = 1'b1; st = 2; cnt = 0;
          end else begin
            cnt++;
            if (spurious && cnt == 2) shift_done = 1'b1;
          end
        end
      end else begin
        cnt++;
        if (cnt == 1 && shift_req !== 1'b0) hs_err++;
        if (cnt == d) begin
          shift_done = 1'b1; last_done = cyc; st = 0;
        end
      end
    end
  end

  // Output monitor: builds period records and counts protocol violations
  initial begin
    logic [1:0]          prev_blank, prev_latch;
    logic [ROW_BITS-1:0] prev_addr;
    int u_cur = 0, prev_rise = -1000, gap_cur = 0;
    int lat_cyc = 0, lat_addr = 0, lat_fs = 0, lat_n = 0;
    prev_blank = 2'b11; prev_latch = 2'b00; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_rise = -1000; lat_n = 0;
      end else begin
        if (!(blank inside {2'b00, 2'b11}) || !(latch inside {2'b00, 2'b11})) illegal++;
        if (latch == 2'b11 && (blank != 2'b11 || prev_latch == 2'b11)) illegal++;
        if (led_addr !== prev_addr && latch !== 2'b11) illegal++;
        if (frame_start === 1'b1) begin
          fs_q.push_back(cyc);
          if (latch !== 2'b11) illegal++;
        end
        if (latch == 2'b11) begin
          lat_cyc = cyc; lat_addr = int'(led_addr); lat_fs = int'(frame_start); lat_n++;
        end
        if (blank == 2'b00 && prev_blank == 2'b11) begin
          u_cur = cyc; gap_cur = cyc - prev_rise;
        end
        if (blank == 2'b11 && prev_blank == 2'b00) begin
          per_q.push_back('{u_cur, cyc - u_cur, last_done, lat_cyc, lat_addr, lat_fs, lat_n, gap_cur});
          prev_rise = cyc; lat_n = 0;
        end
      end
      prev_blank = blank; prev_latch = latch; prev_addr = led_addr;
    end
  end

  task automatic get_period(output per_t p, output bit got);
    int w = 0;
    got = 0;
    p = '{0, 0, 0, 0, 0, 0, 0, 0};
    while (per_q.size() == 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (per_q.size() != 0) begin
      p = per_q.pop_front();
      got = 1;
    end
  endtask

  // Slot order, weighted on-time, latch placement and blank gap per period
  task automatic test_slots(input int n, input string tag);
    per_t p;
    bit   got;
    int   t, exp_len, exp_fs;
    for (int i = 0; i < n; i++) begin
      get_period(p, got);
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("FAIL %s_timeout: no display period seen, required period %0d of %0d", tag, i, n);
        return;
      end
      t       = BASE_TICKS << m_plane;
      exp_len = (p.done - p.u + 1 > t) ? p.done - p.u + 1 : t;
      exp_fs  = (m_row == 0 && m_plane == 0) ? 1 : 0;
      n_checks++;
      if (p.len !== exp_len) begin
        n_fail++;
        $display("FAIL %s_on_time: row %0d plane %0d got %0d required %0d", tag, m_row, m_plane, p.len, exp_len);
      end
      n_checks++;
      if (p.lat_addr !== m_row) begin
        n_fail++;
        $display("FAIL %s_led_addr: got %0d required %0d", tag, p.lat_addr, m_row);
      end
      n_checks++;
      if (p.lat_fs !== exp_fs) begin
        n_fail++;
        $display("FAIL %s_frame_start: row %0d plane %0d got %0d required %0d", tag, m_row, m_plane, p.lat_fs, exp_fs);
      end
      n_checks++;
      if (p.lat_n !== 1 || p.lat_cyc !== p.u - 1) begin
        n_fail++;
        $display("FAIL %s_latch: got %0d pulses at cycle %0d, required 1 pulse at cycle %0d", tag, p.lat_n, p.lat_cyc, p.u - 1);
      end
      if (!m_fresh) begin
        n_checks++;
        if (p.gap !== 2) begin
          n_fail++;
          $display("FAIL %s_blank_gap: got %0d required 2", tag, p.gap);
        end
      end
      m_fresh = 0;
      m_plane++;
      if (m_plane == PLANES) begin
        m_plane = 0;
        m_row   = (m_row + 1) % NROWS;
      end
    end
  endtask

  task automatic test_reset();
    logic [ROW_BITS*2+10:0] exp_v, got_v;
    int w = 0, bad = 0;
    exp_v = {2'b11, 2'b00, {ROW_BITS{1'b0}}, 1'b0, {ROW_BITS{1'b0}}, 3'b000, 1'b0};
    reset = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    got_v = {blank, latch, led_addr, shift_req, shift_row, shift_plane, frame_start};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL reset_power_on: got %b required %b", got_v, exp_v);
    end
    reset = 1'b0; enable = 1'b1;
    rnd_mode = 0; ack_dly = 0; done_dly = 1000;
    while (shift_req !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (w >= 50) begin
      n_fail++;
      $display("FAIL reset_first_req: shift_req got 0 after 50 cycles, required 1");
    end
    repeat (6) @(negedge clk);
    reset = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    got_v = {blank, latch, led_addr, shift_req, shift_row, shift_plane, frame_start};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL reset_mid_wait: got %b required %b", got_v, exp_v);
    end
    repeat (80) begin
      @(negedge clk);
      if (blank !== 2'b11 || latch !== 2'b00 || led_addr !== '0 || shift_req !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_stays_idle: got %0d active cycles required 0", bad);
    end
  endtask

  task automatic test_frame();
    int period_exp = 0;
    for (int p = 0; p < PLANES; p++) period_exp += (BASE_TICKS << p) + 2;
    period_exp *= NROWS;
    rnd_mode = 0; ack_dly = 0; done_dly = 40;
    fs_q.delete();
    m_row = 0; m_plane = 0; m_fresh = 1;
    enable = 1'b1;
    test_slots(NROWS * PLANES + 1, "frame");
    n_checks++;
    if (fs_q.size() < 2) begin
      n_fail++;
      $display("FAIL frame_period: got %0d frame_start pulses required 2", fs_q.size());
    end else if (fs_q[1] - fs_q[0] !== period_exp) begin
      n_fail++;
      $display("FAIL frame_period: got %0d cycles required %0d", fs_q[1] - fs_q[0], period_exp);
    end
  endtask

  task automatic test_slow_shifter();
    slow_p1 = 1;
    test_slots(3 * PLANES, "slow");
    slow_p1 = 0;
  endtask

  task automatic test_ack_delay();
    ack_dly = 10; done_dly = 80; spurious = 1;
    test_slots(2 * PLANES, "ackdly");
    n_checks++;
    if (req_hi !== 11 || req_unstable !== 0) begin
      n_fail++;
      $display("FAIL ack_delay_req_hold: got %0d req cycles (%0d unstable) required 11 (0)", req_hi, req_unstable);
    end
    ack_dly = 0; done_dly = 40; spurious = 0;
  endtask

  task automatic test_coincident();
    done_dly = 62;
    test_slots(PLANES + 2, "coinc62");
    done_dly = 63;
    test_slots(PLANES + 2, "coinc63");
    done_dly = 40;
  endtask

  task automatic test_random();
    rnd_mode = 1;
    test_slots(40, "random");
    rnd_mode = 0;
  endtask

  task automatic test_drain_restart();
    int w = 0, req_seen = 0;
    while (!(latch === 2'b11 && shift_plane === 3'd2) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (w >= 3000) begin
      n_fail++;
      $display("FAIL drain_find_plane2: no plane-2 latch within 3000 cycles");
    end
    enable = 1'b0;
    repeat (800) begin
      @(negedge clk);
      if (shift_req === 1'b1) req_seen++;
    end
    n_checks++;
    if (req_seen !== 0 || blank !== 2'b11) begin
      n_fail++;
      $display("FAIL drain_idle: got %0d req cycles blank=%b required 0 and 11", req_seen, blank);
    end
    test_slots(per_q.size(), "drain");
    n_checks++;
    if (m_plane !== 3) begin
      n_fail++;
      $display("FAIL drain_last_plane: next plane got %0d required 3", m_plane);
    end
    m_row = 0; m_plane = 0; m_fresh = 1;
    enable = 1'b1;
    test_slots(PLANES + 2, "restart");
  endtask

  task automatic test_invariants();
    n_checks++;
    if (illegal !== 0 || hs_err !== 0 || req_unstable !== 0) begin
      n_fail++;
      $display("FAIL invariants: got illegal=%0d handshake=%0d unstable=%0d required all 0", illegal, hs_err, req_unstable);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_slow_shifter();
    test_ack_delay();
    test_coincident();
    test_random();
    test_drain_restart();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
